// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
//   div_state_t : controller states (IDLE waits for a request, CALC runs the steps)
//   cnt_width() : width of the step counter for a given divisor width
package seq_divider_pkg;

   typedef enum logic {IDLE, CALC} div_state_t;

   localparam int unsigned DEFAULT_NUMBITS = 4;

   // Counter must be able to hold 0..NUMBITS.
   function automatic int unsigned cnt_width(input int unsigned numbits);
      return $clog2(numbits + 1);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (combinational).
//   r      : current partial remainder (always < d)
//   q_msb  : next dividend bit shifted into the remainder
//   d      : divisor
//   r_next : remainder after the trial subtraction
//   q_bit  : quotient bit produced by this iteration
module div_step #(
   parameter int unsigned NUMBITS = 4
) (
   input  logic [NUMBITS-1:0] r,
   input  logic               q_msb,
   input  logic [NUMBITS-1:0] d,
   output logic [NUMBITS-1:0] r_next,
   output logic               q_bit
);

   logic [NUMBITS:0] t;
   logic [NUMBITS:0] d_ext;

   always_comb begin
      t      = {r, q_msb};
      d_ext  = {1'b0, d};
      q_bit  = (t >= d_ext);
      // With r < d the restored value is always < d, so it fits in NUMBITS bits.
      r_next = q_bit ? NUMBITS'(t - d_ext) : t[NUMBITS-1:0];
   end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder,
// one quotient bit per clock.
//   clk_in, rst_in          : clock, synchronous active-high reset
//   input_valid             : request strobe, accepted only while busy is low
//   dividend, divisor       : operands, sampled on the acceptance edge
//   busy                    : high while a division is stepping
//   output_ready            : one-cycle pulse when results are valid
//   quotient, remainder     : results, held until the next output_ready
//   div_by_zero, overflow   : error flags for the returned result
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int unsigned NUMBITS = DEFAULT_NUMBITS
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   input_valid,
   input  logic [2*NUMBITS-1:0]   dividend,
   input  logic [NUMBITS-1:0]     divisor,
   output logic                   busy,
   output logic                   output_ready,
   output logic [NUMBITS-1:0]     quotient,
   output logic [NUMBITS-1:0]     remainder,
   output logic                   div_by_zero,
   output logic                   overflow
);

   localparam int unsigned CNT_W = cnt_width(NUMBITS);

   div_state_t         state_q;
   logic [CNT_W-1:0]   cnt_q;
   // Partial remainder kept at N bits: the top bit of the N+1-bit remainder is always 0.
   logic [NUMBITS-1:0] r_q;
   logic [NUMBITS-1:0] q_q;
   logic [NUMBITS-1:0] d_q;
   // Error results are reported one edge after acceptance.
   logic               err_pend_q;
   logic               err_dbz_q;

   logic [NUMBITS-1:0] dividend_hi;
   logic [NUMBITS-1:0] dividend_lo;
   logic [NUMBITS-1:0] step_r;
   logic               step_bit;

   assign dividend_hi = dividend[2*NUMBITS-1:NUMBITS];
   assign dividend_lo = dividend[NUMBITS-1:0];

   div_step #(
      .NUMBITS (NUMBITS)
   ) u_step (
      .r      (r_q),
      .q_msb  (q_q[NUMBITS-1]),
      .d      (d_q),
      .r_next (step_r),
      .q_bit  (step_bit)
   );

   always_comb begin
      busy = (state_q == CALC);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         r_q          <= '0;
         q_q          <= '0;
         d_q          <= '0;
         err_pend_q   <= 1'b0;
         err_dbz_q    <= 1'b0;
         output_ready <= 1'b0;
         quotient     <= '0;
         remainder    <= '0;
         div_by_zero  <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         output_ready <= 1'b0;
         err_pend_q   <= 1'b0;

         if (err_pend_q) begin
            output_ready <= 1'b1;
            quotient     <= '0;
            remainder    <= '0;
            div_by_zero  <= err_dbz_q;
            overflow     <= ~err_dbz_q;
         end

         case (state_q)
            IDLE: begin
               if (input_valid) begin
                  if (divisor == '0) begin
                     err_pend_q <= 1'b1;
                     err_dbz_q  <= 1'b1;
                  end else if (dividend_hi >= divisor) begin
                     err_pend_q <= 1'b1;
                     err_dbz_q  <= 1'b0;
                  end else begin
                     d_q     <= divisor;
                     r_q     <= dividend_hi;
                     q_q     <= dividend_lo;
                     cnt_q   <= '0;
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               r_q   <= step_r;
               q_q   <= {q_q[NUMBITS-2:0], step_bit};
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(NUMBITS - 1)) begin
                  state_q      <= IDLE;
                  output_ready <= 1'b1;
                  quotient     <= {q_q[NUMBITS-2:0], step_bit};
                  remainder    <= step_r;
                  div_by_zero  <= 1'b0;
                  overflow     <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
